// File: rtl/branch_resolve_unit.sv
// Resolves branches at the end of EX against the in-order queue of IF-stage predictions.
// Emits the predictor training stream and a front-end redirect, flushing younger entries.
module branch_resolve_unit #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        if_valid,
    output logic        if_ready,
    input  logic [31:0] if_pc,
    input  logic        if_pred_taken,
    input  logic [31:0] if_pred_target,

    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [31:0] ex_pc,
    input  logic        ex_is_branch,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,

    input  logic        ext_flush,

    output logic        bpu_update,
    output logic [31:0] bpu_pc,
    output logic        bpu_taken,
    output logic [31:0] bpu_target,
    output logic        bpu_correct,

    output logic        redirect_valid,
    output logic [31:0] redirect_pc,

    output logic        desync,
    output logic [31:0] mispredict_count
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0] CNT_ONE    = (PTR_W + 1)'(1);

    // Prediction queue storage; only the pointers are reset.
    logic [31:0]      q_pc     [DEPTH];
    logic             q_taken  [DEPTH];
    logic [31:0]      q_target [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;

    logic             full;
    logic             empty;
    logic             if_fire;
    logic             ex_fire;

    logic [31:0]      head_pc;
    logic             head_taken;
    logic [31:0]      head_target;

    logic [31:0]      pred_next;
    logic [31:0]      act_next;
    logic             mismatch;
    logic             correct;
    logic             resolve_valid;
    logic             resolve_flush;

    // Handshake: a transfer happens on a rising edge where valid && ready are both
    // high; ready depends only on queue occupancy, never on the same cycle's inputs.
    assign full     = (count == FULL_COUNT);
    assign empty    = (count == '0);
    assign if_ready = !full;
    assign ex_ready = !empty;
    assign if_fire  = if_valid && if_ready;
    assign ex_fire  = ex_valid && ex_ready;

    assign head_pc     = q_pc[head];
    assign head_taken  = q_taken[head];
    assign head_target = q_target[head];

    always_comb begin
        pred_next     = head_taken ? head_target : (head_pc + 32'd4);
        act_next      = ex_taken ? ex_target : (ex_pc + 32'd4);
        mismatch      = (ex_pc != head_pc);
        correct       = !mismatch && (pred_next == act_next);
        resolve_valid = ex_fire && !ext_flush;
        resolve_flush = resolve_valid && !correct;
    end

    // A dropped push may still write the slot at tail; tail does not advance, so it is invisible.
    always_ff @(posedge clk) begin
        if (if_fire) begin
            q_pc[tail]     <= if_pc;
            q_taken[tail]  <= if_pred_taken;
            q_target[tail] <= if_pred_target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (ext_flush || resolve_flush) begin
            head  <= tail;
            count <= '0;
        end else begin
            if (if_fire) begin
                tail <= tail + PTR_ONE;
            end
            if (ex_fire) begin
                head <= head + PTR_ONE;
            end
            case ({if_fire, ex_fire})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bpu_update     <= 1'b0;
            bpu_pc         <= '0;
            bpu_taken      <= 1'b0;
            bpu_target     <= '0;
            bpu_correct    <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            bpu_update     <= 1'b0;
            redirect_valid <= 1'b0;
            if (resolve_valid) begin
                bpu_update     <= ex_is_branch && !mismatch;
                bpu_pc         <= ex_pc;
                bpu_taken      <= ex_taken;
                bpu_target     <= ex_target;
                bpu_correct    <= correct;
                redirect_valid <= !correct;
                redirect_pc    <= act_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            desync           <= 1'b0;
            mispredict_count <= '0;
        end else begin
            if (resolve_valid && mismatch) begin
                desync <= 1'b1;
            end
            if (resolve_flush && (mispredict_count != 32'hFFFF_FFFF)) begin
                mispredict_count <= mispredict_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: stimulus pushes expected resolution results,
// an independent monitor pops and compares them whenever a training or redirect pulse appears.
module tb_branch_resolve_unit;

    logic        clk;
    logic        reset;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic [31:0] if_pred_target;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_pc;
    logic        ex_is_branch;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ext_flush;
    logic        bpu_update;
    logic [31:0] bpu_pc;
    logic        bpu_taken;
    logic [31:0] bpu_target;
    logic        bpu_correct;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        desync;
    logic [31:0] mispredict_count;

    typedef struct packed {
        logic        upd;
        logic [31:0] pc;
        logic        taken;
        logic [31:0] tgt;
        logic        cor;
        logic        red;
        logic [31:0] rpc;
    } res_t;

    localparam int RES_W = $bits(res_t);

    logic [RES_W-1:0] exp_q[$];
    int total;
    int bad;

    branch_resolve_unit #(.DEPTH(4), .PTR_W(2)) dut (
        .clk              (clk),
        .reset            (reset),
        .if_valid         (if_valid),
        .if_ready         (if_ready),
        .if_pc            (if_pc),
        .if_pred_taken    (if_pred_taken),
        .if_pred_target   (if_pred_target),
        .ex_valid         (ex_valid),
        .ex_ready         (ex_ready),
        .ex_pc            (ex_pc),
        .ex_is_branch     (ex_is_branch),
        .ex_taken         (ex_taken),
        .ex_target        (ex_target),
        .ext_flush        (ext_flush),
        .bpu_update       (bpu_update),
        .bpu_pc           (bpu_pc),
        .bpu_taken        (bpu_taken),
        .bpu_target       (bpu_target),
        .bpu_correct      (bpu_correct),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .desync           (desync),
        .mispredict_count (mispredict_count)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_res(input logic upd, input logic [31:0] pc, input logic taken,
                              input logic [31:0] tgt, input logic cor, input logic red,
                              input logic [31:0] rpc);
        res_t r;
        r.upd   = upd;
        r.pc    = pc;
        r.taken = taken;
        r.tgt   = tgt;
        r.cor   = cor;
        r.red   = red;
        r.rpc   = rpc;
        exp_q.push_back(RES_W'(r));
    endtask

    // Driver tasks: inputs change on the falling edge, DUT samples on the rising edge.
    task automatic push(input logic [31:0] pc, input logic pt, input logic [31:0] tgt);
        check("push_ready", {31'd0, if_ready}, 32'd1);
        if_valid       = 1'b1;
        if_pc          = pc;
        if_pred_taken  = pt;
        if_pred_target = tgt;
        @(negedge clk);
        if_valid = 1'b0;
    endtask

    task automatic pop(input logic [31:0] pc, input logic br, input logic tk,
                       input logic [31:0] tgt, input logic e_upd, input logic e_cor,
                       input logic e_red, input logic [31:0] e_rpc);
        check("pop_ready", {31'd0, ex_ready}, 32'd1);
        ex_valid     = 1'b1;
        ex_pc        = pc;
        ex_is_branch = br;
        ex_taken     = tk;
        ex_target    = tgt;
        expect_res(e_upd, pc, tk, tgt, e_cor, e_red, e_rpc);
        @(negedge clk);
        ex_valid = 1'b0;
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!reset && (bpu_update || redirect_valid)) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse: got update=%0b redirect=%0b pc=%h, expected no pulse",
                         bpu_update, redirect_valid, bpu_pc);
            end else begin
                res_t e;
                e = res_t'(exp_q.pop_front());
                check("bpu_update",     {31'd0, bpu_update},     {31'd0, e.upd});
                check("bpu_pc",         bpu_pc,                  e.pc);
                check("bpu_taken",      {31'd0, bpu_taken},      {31'd0, e.taken});
                check("bpu_target",     bpu_target,              e.tgt);
                check("bpu_correct",    {31'd0, bpu_correct},    {31'd0, e.cor});
                check("redirect_valid", {31'd0, redirect_valid}, {31'd0, e.red});
                if (e.red) begin
                    check("redirect_pc", redirect_pc, e.rpc);
                end
            end
        end
    end

    initial begin
        total          = 0;
        bad            = 0;
        reset          = 1'b1;
        if_valid       = 1'b0;
        if_pc          = '0;
        if_pred_taken  = 1'b0;
        if_pred_target = '0;
        ex_valid       = 1'b0;
        ex_pc          = '0;
        ex_is_branch   = 1'b0;
        ex_taken       = 1'b0;
        ex_target      = '0;
        ext_flush      = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        check("rst_if_ready",  {31'd0, if_ready},       32'd1);
        check("rst_ex_ready",  {31'd0, ex_ready},       32'd0);
        check("rst_update",    {31'd0, bpu_update},     32'd0);
        check("rst_redirect",  {31'd0, redirect_valid}, 32'd0);
        check("rst_desync",    {31'd0, desync},         32'd0);
        check("rst_mcount",    mispredict_count,        32'd0);
        check("rst_bpu_pc",    bpu_pc,                  32'd0);

        // Correctly predicted not-taken branch
        push(32'h8000_0000, 1'b0, 32'h0);
        pop(32'h8000_0000, 1'b1, 1'b0, 32'h1234_5678, 1'b1, 1'b1, 1'b0, 32'h8000_0004);
        check("t1_ex_ready", {31'd0, ex_ready}, 32'd0);
        @(negedge clk);
        check("t1_pulse_end", {31'd0, bpu_update}, 32'd0);

        // Predicted taken, actually not taken; same-cycle push is dropped by the flush
        push(32'h8000_0010, 1'b1, 32'h8000_0100);
        push(32'h8000_0014, 1'b0, 32'h0);
        push(32'h8000_0018, 1'b0, 32'h0);
        if_valid      = 1'b1;
        if_pc         = 32'h8000_0050;
        if_pred_taken = 1'b0;
        pop(32'h8000_0010, 1'b1, 1'b0, 32'h8000_0100, 1'b1, 1'b0, 1'b1, 32'h8000_0014);
        if_valid = 1'b0;
        check("t2_mcount",   mispredict_count,        32'd1);
        check("t2_ex_ready", {31'd0, ex_ready},       32'd0);

        // Non-branch predicted taken
        push(32'h8000_0020, 1'b1, 32'h8000_0040);
        pop(32'h8000_0020, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h8000_0024);
        check("t3_mcount", mispredict_count, 32'd2);

        // Fill, blocked push during pop, then FIFO order and pointer wrap
        push(32'h8000_1000, 1'b0, 32'h0);
        push(32'h8000_1004, 1'b1, 32'h8000_2000);
        push(32'h8000_2000, 1'b0, 32'h0);
        push(32'h8000_2004, 1'b0, 32'h0);
        check("t4_full", {31'd0, if_ready}, 32'd0);
        if_valid      = 1'b1;
        if_pc         = 32'h8000_3000;
        if_pred_taken = 1'b0;
        pop(32'h8000_1000, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);
        if_valid = 1'b0;
        check("t4_ready_again", {31'd0, if_ready}, 32'd1);
        pop(32'h8000_1004, 1'b1, 1'b1, 32'h8000_2000, 1'b1, 1'b1, 1'b0, 32'h0);
        pop(32'h8000_2000, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0);
        pop(32'h8000_2004, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0);
        check("t4_drained", {31'd0, ex_ready}, 32'd0);
        push(32'h8000_4000, 1'b0, 32'h0);
        push(32'h8000_4004, 1'b1, 32'h8000_4100);
        push(32'h8000_4100, 1'b0, 32'h0);
        push(32'h8000_4104, 1'b0, 32'h0);
        check("t4_full_wrap", {31'd0, if_ready}, 32'd0);
        pop(32'h8000_4000, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0);
        pop(32'h8000_4004, 1'b1, 1'b1, 32'h8000_4100, 1'b1, 1'b1, 1'b0, 32'h0);
        pop(32'h8000_4100, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0);
        pop(32'h8000_4104, 1'b1, 1'b1, 32'h8000_4108, 1'b1, 1'b1, 1'b0, 32'h0);
        check("t4_mcount", mispredict_count, 32'd2);

        // PC mismatch against queue head
        push(32'h8000_0030, 1'b0, 32'h0);
        pop(32'h8000_0034, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h8000_0038);
        check("t5_desync", {31'd0, desync},  32'd1);
        check("t5_mcount", mispredict_count, 32'd3);

        // ext_flush with simultaneous resolve and push
        push(32'h8000_0040, 1'b0, 32'h0);
        push(32'h8000_0044, 1'b0, 32'h0);
        ext_flush     = 1'b1;
        ex_valid      = 1'b1;
        ex_pc         = 32'h8000_0040;
        ex_is_branch  = 1'b1;
        ex_taken      = 1'b1;
        ex_target     = 32'h8000_0800;
        if_valid      = 1'b1;
        if_pc         = 32'h8000_0048;
        @(negedge clk);
        ext_flush = 1'b0;
        ex_valid  = 1'b0;
        if_valid  = 1'b0;
        check("t6_ex_ready", {31'd0, ex_ready},       32'd0);
        check("t6_update",   {31'd0, bpu_update},     32'd0);
        check("t6_redirect", {31'd0, redirect_valid}, 32'd0);
        check("t6_mcount",   mispredict_count,        32'd3);
        check("t6_desync",   {31'd0, desync},         32'd1);

        // Reset with entries in flight
        push(32'h8000_0060, 1'b0, 32'h0);
        push(32'h8000_0064, 1'b0, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("r2_ex_ready", {31'd0, ex_ready}, 32'd0);
        check("r2_if_ready", {31'd0, if_ready}, 32'd1);
        check("r2_desync",   {31'd0, desync},   32'd0);
        check("r2_mcount",   mispredict_count,  32'd0);
        check("r2_bpu_pc",   bpu_pc,            32'd0);
        check("r2_rpc",      redirect_pc,       32'd0);
        @(negedge clk);
        check("pending_results", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
